// File: rtl/hit_receiver.sv
// hit_receiver: defender-side hit detection, damage accumulation, knockback launch and
// hitstun/invulnerability sequencing. Define HIT_DAMAGE_SCALE_EN to scale knockback by damage.
module hit_receiver #(
  parameter int unsigned HITSTUN_BASE  = 8,
  parameter int unsigned INVULN_FRAMES = 30,
  parameter int unsigned DAMAGE_MAX    = 999
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic [31:0] attack,
  input  logic [31:0] knockback,
  input  logic        respawn,
  output logic [15:0] damage,
  output logic [31:0] hit_vel,
  output logic        hitstun,
  output logic        invuln,
  output logic        hit_pulse
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HITSTUN = 2'd1,
    S_INVULN  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  count;
  logic [7:0]  count_next;
  logic        landed_p1;
  logic        hit_edge;
  logic        hit_take;
  logic        last_tick;
  logic [16:0] dmg_sum;
  logic [15:0] new_damage;
  logic [7:0]  stun_len;
  logic [31:0] launch_vel;
  logic        unused_attack;

  // Lowest-index set type bit wins; a typeless hit still costs one percent.
  function automatic logic [4:0] damage_inc(input logic [9:0] kind);
    if (|kind[3:0])      return 5'd16;
    else if (kind[4])    return 5'd3;
    else if (|kind[6:5]) return 5'd10;
    else if (|kind[8:7]) return 5'd8;
    else if (kind[9])    return 5'd6;
    else                 return 5'd1;
  endfunction

  function automatic logic [15:0] sat_damage(input logic [16:0] sum);
    if (sum > 17'(DAMAGE_MAX)) return 16'(DAMAGE_MAX);
    return sum[15:0];
  endfunction

  function automatic logic signed [15:0] decay(input logic signed [15:0] v);
    if (v > -16'sd8 && v < 16'sd8) return 16'sd0;
    return v - (v >>> 3);
  endfunction

`ifdef HIT_DAMAGE_SCALE_EN
  function automatic logic signed [15:0] sat16(input logic signed [24:0] x);
    if (x > 25'sd32767)  return 16'sh7FFF;
    if (x < -25'sd32768) return 16'sh8000;
    return x[15:0];
  endfunction

  // kb * (64 + min(damage,255)) fits a 25-bit signed product; >>> floors toward -inf.
  function automatic logic signed [15:0] scale_kb(input logic signed [15:0] kb,
                                                  input logic [15:0]        dmg);
    logic [7:0]         s;
    logic [9:0]         factor;
    logic signed [24:0] kb_x;
    logic signed [24:0] factor_x;
    logic signed [24:0] prod;
    s        = (dmg > 16'd255) ? 8'd255 : dmg[7:0];
    factor   = {2'b00, s} + 10'd64;
    kb_x     = {{9{kb[15]}}, kb};
    factor_x = {15'd0, factor};
    prod     = kb_x * factor_x;
    return sat16(prod >>> 6);
  endfunction
`endif

  assign unused_attack = ^attack[31:11];
  assign hit_edge      = attack[0] & ~landed_p1;
  assign hit_take      = hit_edge & ~respawn & (state == S_IDLE);
  assign last_tick     = frame_tick & (count == 8'd1);
  assign dmg_sum       = {1'b0, damage} + {12'd0, damage_inc(attack[10:1])};
  assign new_damage    = sat_damage(dmg_sum);
  assign stun_len      = 8'(HITSTUN_BASE) + new_damage[12:5];

`ifdef HIT_DAMAGE_SCALE_EN
  assign launch_vel = {scale_kb(knockback[31:16], new_damage),
                       scale_kb(knockback[15:0], new_damage)};
`else
  assign launch_vel = knockback;
`endif

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      count <= 8'd0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Next-state logic; respawn overrides hits and ticks
  always_comb begin
    state_next = state;
    count_next = count;
    if (respawn) begin
      state_next = S_INVULN;
      count_next = 8'(INVULN_FRAMES);
    end else begin
      case (state)
        S_IDLE: begin
          if (hit_edge) begin
            state_next = S_HITSTUN;
            count_next = stun_len;
          end
        end
        S_HITSTUN: begin
          if (last_tick) begin
            state_next = S_INVULN;
            count_next = 8'(INVULN_FRAMES);
          end else if (frame_tick) begin
            count_next = count - 8'd1;
          end
        end
        S_INVULN: begin
          if (frame_tick) begin
            count_next = count - 8'd1;
            if (count == 8'd1) state_next = S_IDLE;
          end
        end
        default: begin
          state_next = S_IDLE;
          count_next = 8'd0;
        end
      endcase
    end
  end

  // Output decode
  always_comb begin
    hitstun = (state == S_HITSTUN);
    invuln  = (state == S_INVULN);
  end

  // Damage / velocity stage
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      landed_p1 <= 1'b0;
      damage    <= '0;
      hit_vel   <= '0;
      hit_pulse <= 1'b0;
    end else begin
      landed_p1 <= attack[0];
      hit_pulse <= hit_take;
      if (respawn) begin
        damage  <= '0;
        hit_vel <= '0;
      end else if (hit_take) begin
        damage  <= new_damage;
        hit_vel <= launch_vel;
      end else if (state == S_HITSTUN && frame_tick) begin
        if (last_tick) hit_vel <= '0;
        else           hit_vel <= {decay(hit_vel[31:16]), decay(hit_vel[15:0])};
      end
    end
  end

endmodule

// File: doc/hit_receiver.md
# hit_receiver

Defender-side stage directly downstream of the attack coprocessor. It consumes the attacker's `attack` status word and `knockback` vector and performs these steps:
- detects new landed hits;
- accumulates the defender's damage percent;
- scales knockback by damage;
- runs the hitstun/invulnerability state machine;
- outputs a decaying launch velocity to the physics/movement stage.

## Interface
Parameters:
- `HITSTUN_BASE`, 8: base hitstun length in frames (8-bit).
- `INVULN_FRAMES`, 30: post-hitstun and post-respawn invulnerability length in frames (8-bit, must be ≥1).
- `DAMAGE_MAX`, 999: saturation value of the damage percent.

Ports:
- `clock`  in  1  system clock; only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `frame_tick`  in  1  one-cycle pulse per game frame.
- `attack`  in  32  attacker status word:
  - bit0 = hit landed;
  - bit1 smashU, bit2 smashD, bit3 smashL, bit4 smashR;
  - bit5 jab;
  - bit6 specialU, bit7 specialD, bit8 specialL, bit9 specialR, bit10 specialN;
  - bit11 attacking.
- `knockback`  in  32  signed 16-bit X in [31:16], signed 16-bit Y in [15:0].
- `respawn`  in  1  one-cycle pulse; clears damage and grants invulnerability.
- `damage`  out  16  accumulated damage percent, unsigned.
- `hit_vel`  out  32  launch velocity, signed X in [31:16], signed Y in [15:0].
- `hitstun`  out  1  high in HITSTUN.
- `invuln`  out  1  high in INVULN.
- `hit_pulse`  out  1  one-cycle pulse when a hit is accepted.

## Operation
States:
- IDLE (reset state).
- HITSTUN.
- INVULN.

Hit acceptance:
- A hit is a 0→1 edge of `attack[0]`, using a registered previous value of `attack[0]`, taken while in IDLE.
- Edges arriving in HITSTUN or INVULN are ignored. The edge detector still tracks `attack[0]` in those states.

Damage increment, taken from the lowest-index set bit in [10:1]:
- smash U/D/L/R: 16.
- jab: 3.
- special U/D: 10.
- special L/R: 8.
- special N: 6.
- No type bit set: 1.

Damage update: `new_damage = min(damage + inc, DAMAGE_MAX)`.

Velocity scaling, per component:
- `s = min(new_damage, 255)`.
- `v = (kb * (64 + s)) >>> 6`. Use a 25-bit signed product; the arithmetic shift floors toward −∞.
- Saturate the result to [−32768, 32767].

On an accepted hit:
- `damage` ← `new_damage`.
- `hit_vel` ← scaled vector.
- Counter ← `HITSTUN_BASE + (new_damage >> 5)`.
- State → HITSTUN.
- `hit_pulse` = 1.

HITSTUN, on each `frame_tick`:
- Each velocity component v ← v − (v >>> 3).
- If |v| < 8 before the update, v ← 0.
- Counter decrements.
- When the counter is 1 on a tick: `hit_vel` ← 0, counter ← `INVULN_FRAMES`, state → INVULN.

INVULN, on each `frame_tick`:
- Counter decrements.
- When the counter is 1 on a tick: state → IDLE.

`respawn`, from any state:
- `damage` ← 0, `hit_vel` ← 0, counter ← `INVULN_FRAMES`, state → INVULN.
- `respawn` has priority over a simultaneous hit and over `frame_tick`.
- `hit_pulse` stays 0 on that cycle.

`hit_vel` is 0 whenever the state is not HITSTUN.

## Timing
- All outputs are registered.
- Reset values: `damage` = 0, `hit_vel` = 0, `hitstun` = 0, `invuln` = 0, `hit_pulse` = 0, state IDLE, counter 0, edge register 0.
- Latency: `attack[0]` rises in cycle N → `hit_pulse`, `damage`, `hit_vel` and `hitstun` all update at edge N+1.
- Simultaneous hit and `frame_tick` in IDLE: the hit is taken and the tick is ignored that cycle.
- `attack[0]` held high across the return to IDLE: no hit is taken. A new rising edge is required.
- `reset` asserted mid-HITSTUN: all state clears immediately, asynchronously.
- Hitstun length in frames equals the loaded counter value. The INVULN length is exactly `INVULN_FRAMES` ticks.

## Configuration
`HIT_DAMAGE_SCALE_EN`:
- Defined: knockback is scaled by damage as in Operation.
- Undefined: `hit_vel` ← `knockback` unmodified on an accepted hit, and the scaling multipliers are not synthesized. Decay, hitstun length and damage accumulation are unchanged.

## Test plan
- Reset, then smashR hit (`attack` = 0x0811, `knockback` = 0x080000A0) with damage 0. Required at N+1:
  - `damage` = 16, `hit_vel` = 0x0A0000C8, `hit_pulse` = 1, `hitstun` = 1.
  - After 1 tick, X = 0x08C0.
- smashD hit, `knockback` = 0x0000F7FE, damage 0: Y = 0xF5FD (−2563, flooring check).
- Hit at damage 0: `hitstun` stays high for exactly 8 ticks, then `invuln` is high for 30 ticks, then IDLE. A second hit during either window leaves `damage` unchanged.
- Damage 995 plus a smash hit: `damage` = 999. The scale factor uses s = 255, and an 0x7FFF knockback component saturates to 0x7FFF.
- `respawn` coincident with a hit edge in IDLE: `damage` = 0, `invuln` = 1, `hit_pulse` = 0.
- Build with `HIT_DAMAGE_SCALE_EN` undefined and run the first scenario: `hit_vel` = 0x080000A0 and `damage` = 16.
